// File: rtl/cache_model_lru.sv
// Set-associative cache tag/status model with true-LRU age counters, selectable write policy,
// sequential whole-cache flush and saturating statistics counters. No data is stored.
module cache_model_lru #(
    parameter int SETS         = 1024,
    parameter int ASSOC        = 4,
    parameter int LINESIZE     = 16,
    parameter int ADDRESS_SIZE = 32,
    parameter int WRITE_POLICY = 0,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_rw,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic                    resp_evict,
    output logic                    resp_writeback,
    input  logic                    flush_req,
    output logic                    flush_done,
    input  logic                    stats_clr,
    output logic [CNT_WIDTH-1:0]    accesses,
    output logic [CNT_WIDTH-1:0]    reads,
    output logic [CNT_WIDTH-1:0]    writes,
    output logic [CNT_WIDTH-1:0]    hits,
    output logic [CNT_WIDTH-1:0]    misses,
    output logic [CNT_WIDTH-1:0]    evictions,
    output logic [CNT_WIDTH-1:0]    writebacks
);

    localparam int OFF_W = $clog2(LINESIZE);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDRESS_SIZE - OFF_W - IDX_W;
    localparam int WAY_W = $clog2(ASSOC);
    localparam int INC_W = $clog2(ASSOC + 1);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [WAY_W-1:0] way_t;
    typedef logic [INC_W-1:0] inc_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam inc_t INC_ONE = inc_t'(1);
    localparam way_t AGE_OLDEST = way_t'(ASSOC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_UPDATE,
        S_FLUSH
    } state_e;

    state_e state_q, state_d;

    logic req_rw_q;
    idx_t req_idx_q;
    tag_t req_tag_q;
    idx_t flush_idx_q;

    logic hit_q, evict_q, wb_q;
    way_t way_q;

    logic resp_valid_q, resp_hit_q, resp_evict_q, resp_wb_q;

    tag_t             tag_q   [SETS][ASSOC];
    logic [ASSOC-1:0] valid_q [SETS];
    logic [ASSOC-1:0] dirty_q [SETS];
    way_t             age_q   [SETS][ASSOC];

    logic [CNT_WIDTH-1:0] acc_q, rd_q, wr_q, hit_cnt_q, miss_q, evict_cnt_q, wb_cnt_q;

    logic unused_offset;
    assign unused_offset = ^req_addr[OFF_W-1:0];

    // ---------------- lookup of the captured set ----------------
    logic [ASSOC-1:0] hit_vec;
    logic             lk_hit, any_inv, allocate, lk_evict, lk_wb;
    way_t             hit_way, inv_way, lru_way, lk_sel;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        hit_vec = '0;
        lk_hit  = 1'b0;
        hit_way = '0;
        inv_way = '0;
        lru_way = '0;
        for (int w = 0; w < ASSOC; w++) begin
            hit_vec[w] = valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q);
            if (hit_vec[w]) begin
                lk_hit  = 1'b1;
                hit_way = way_t'(w);
            end
            if (age_q[req_idx_q][w] == AGE_OLDEST) lru_way = way_t'(w);
        end
        // Scan downwards so the lowest-indexed invalid way wins.
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (!valid_q[req_idx_q][w]) inv_way = way_t'(w);
        end
    end

    assign any_inv  = ~&valid_q[req_idx_q];
    assign allocate = !req_rw_q || (WRITE_POLICY == 0);
    assign lk_evict = !lk_hit && allocate && !any_inv;
    assign lk_wb    = lk_evict && dirty_q[req_idx_q][lru_way];
    assign lk_sel   = lk_hit ? hit_way : (any_inv ? inv_way : lru_way);

    // ---------------- FSM ----------------
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        flush_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = !flush_req;
                if (flush_req)      state_d = S_FLUSH;
                else if (req_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: state_d = S_UPDATE;
            S_UPDATE: state_d = S_IDLE;
            S_FLUSH: begin
                if (flush_idx_q == '1) begin
                    flush_done = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            req_rw_q     <= 1'b0;
            req_idx_q    <= '0;
            req_tag_q    <= '0;
            flush_idx_q  <= '0;
            hit_q        <= 1'b0;
            evict_q      <= 1'b0;
            wb_q         <= 1'b0;
            way_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_evict_q <= 1'b0;
            resp_wb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_valid && req_ready) begin
                req_rw_q  <= req_rw;
                req_idx_q <= req_addr[OFF_W +: IDX_W];
                req_tag_q <= req_addr[ADDRESS_SIZE-1 -: TAG_W];
            end
            if (state_q == S_LOOKUP) begin
                hit_q   <= lk_hit;
                evict_q <= lk_evict;
                wb_q    <= lk_wb;
                way_q   <= lk_sel;
            end
            flush_idx_q  <= (state_q == S_FLUSH) ? flush_idx_q + 1'b1 : '0;
            resp_valid_q <= (state_q == S_UPDATE);
            resp_hit_q   <= (state_q == S_UPDATE) && hit_q;
            resp_evict_q <= (state_q == S_UPDATE) && evict_q;
            resp_wb_q    <= (state_q == S_UPDATE) && wb_q;
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_hit       = resp_hit_q;
    assign resp_evict     = resp_evict_q;
    assign resp_writeback = resp_wb_q;

    // ---------------- tag/status arrays ----------------
    logic fill;
    assign fill = (state_q == S_UPDATE) && !hit_q && allocate;

    // NOTE: tags are never reset; a stale tag is harmless because its valid bit is cleared.
    always_ff @(posedge clk) begin
        if (fill) tag_q[req_idx_q][way_q] <= req_tag_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < ASSOC; w++) age_q[s][w] <= way_t'(w);
            end
        end else if (state_q == S_UPDATE) begin
            if (hit_q || allocate) begin
                for (int v = 0; v < ASSOC; v++) begin
                    if (way_t'(v) == way_q)
                        age_q[req_idx_q][v] <= '0;
                    else if (age_q[req_idx_q][v] < age_q[req_idx_q][way_q])
                        age_q[req_idx_q][v] <= age_q[req_idx_q][v] + 1'b1;
                end
            end
            if (fill) begin
                valid_q[req_idx_q][way_q] <= 1'b1;
                dirty_q[req_idx_q][way_q] <= req_rw_q;
            end
            if (hit_q && req_rw_q && (WRITE_POLICY == 0))
                dirty_q[req_idx_q][way_q] <= 1'b1;
        end else if (state_q == S_FLUSH) begin
            valid_q[flush_idx_q] <= '0;
            dirty_q[flush_idx_q] <= '0;
        end
    end

    // ---------------- statistics ----------------
    inc_t flush_cnt, wb_inc;

    always_comb begin
        flush_cnt = '0;
        for (int w = 0; w < ASSOC; w++)
            flush_cnt = flush_cnt + inc_t'(valid_q[flush_idx_q][w] & dirty_q[flush_idx_q][w]);
    end

    assign wb_inc = (state_q == S_UPDATE) ? inc_t'(wb_q) :
                    (state_q == S_FLUSH)  ? flush_cnt : '0;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a, input inc_t b);
        logic [CNT_WIDTH+INC_W-1:0] s;
        s = {{INC_W{1'b0}}, a} + {{CNT_WIDTH{1'b0}}, b};
        if (s > {{INC_W{1'b0}}, CNT_MAX}) return CNT_MAX;
        return s[CNT_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || stats_clr) begin
            acc_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            hit_cnt_q   <= '0;
            miss_q      <= '0;
            evict_cnt_q <= '0;
            wb_cnt_q    <= '0;
        end else begin
            if (state_q == S_UPDATE) begin
                acc_q <= sat_add(acc_q, INC_ONE);
                if (req_rw_q) wr_q      <= sat_add(wr_q, INC_ONE);
                else          rd_q      <= sat_add(rd_q, INC_ONE);
                if (hit_q)    hit_cnt_q <= sat_add(hit_cnt_q, INC_ONE);
                else          miss_q    <= sat_add(miss_q, INC_ONE);
                if (evict_q)  evict_cnt_q <= sat_add(evict_cnt_q, INC_ONE);
            end
            wb_cnt_q <= sat_add(wb_cnt_q, wb_inc);
        end
    end

    assign accesses   = acc_q;
    assign reads      = rd_q;
    assign writes     = wr_q;
    assign hits       = hit_cnt_q;
    assign misses     = miss_q;
    assign evictions  = evict_cnt_q;
    assign writebacks = wb_cnt_q;

endmodule

// File: tb/tb_cache_model_lru.sv
// Directed bench for cache_model_lru: three instances (write-back, write-through, 2-bit counters)
// in the SETS=4 / ASSOC=2 / LINESIZE=16 / ADDRESS_SIZE=16 configuration.
module tb_cache_model_lru;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset      [N];
    logic        req_valid  [N];
    logic        req_rw     [N];
    logic [15:0] req_addr   [N];
    logic        flush_req  [N];
    logic        stats_clr  [N];
    logic        req_ready  [N];
    logic        resp_valid [N];
    logic        resp_hit   [N];
    logic        resp_evict [N];
    logic        resp_wb    [N];
    logic        flush_done [N];

    logic [31:0] acc [2], rd [2], wr [2], hit [2], mis [2], evc [2], wbc [2];
    logic [1:0]  acc2, rd2, wr2, hit2, mis2, evc2, wbc2;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cache_model_lru #(
            .SETS(4), .ASSOC(2), .LINESIZE(16), .ADDRESS_SIZE(16),
            .WRITE_POLICY(g), .CNT_WIDTH(32)
        ) u_dut (
            .clk(clk), .reset(reset[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_rw(req_rw[g]), .req_addr(req_addr[g]),
            .resp_valid(resp_valid[g]), .resp_hit(resp_hit[g]),
            .resp_evict(resp_evict[g]), .resp_writeback(resp_wb[g]),
            .flush_req(flush_req[g]), .flush_done(flush_done[g]),
            .stats_clr(stats_clr[g]),
            .accesses(acc[g]), .reads(rd[g]), .writes(wr[g]), .hits(hit[g]),
            .misses(mis[g]), .evictions(evc[g]), .writebacks(wbc[g])
        );
    end

    cache_model_lru #(
        .SETS(4), .ASSOC(2), .LINESIZE(16), .ADDRESS_SIZE(16),
        .WRITE_POLICY(0), .CNT_WIDTH(2)
    ) u_dut_sat (
        .clk(clk), .reset(reset[2]),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_rw(req_rw[2]), .req_addr(req_addr[2]),
        .resp_valid(resp_valid[2]), .resp_hit(resp_hit[2]),
        .resp_evict(resp_evict[2]), .resp_writeback(resp_wb[2]),
        .flush_req(flush_req[2]), .flush_done(flush_done[2]),
        .stats_clr(stats_clr[2]),
        .accesses(acc2), .reads(rd2), .writes(wr2), .hits(hit2),
        .misses(mis2), .evictions(evc2), .writebacks(wbc2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request from a negedge with the instance idle; return at the negedge where resp_valid is seen.
    task automatic xact(input int d, input logic rw, input logic [15:0] a,
                        input logic eh, input logic ee, input logic ew, input string tag);
        int  n;
        bit  seen;
        req_valid[d] = 1'b1;
        req_rw[d]    = rw;
        req_addr[d]  = a;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        n    = 1;
        seen = 1'b0;
        while (!seen && n < 8) begin
            if (resp_valid[d]) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check({tag, "_lat"}, n, 3);
        check({tag, "_hit"}, resp_hit[d], eh);
        check({tag, "_evict"}, resp_evict[d], ee);
        check({tag, "_wb"}, resp_wb[d], ew);
    endtask

    task automatic clear_stats(input int d);
        stats_clr[d] = 1'b1;
        @(negedge clk);
        stats_clr[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        for (int i = 0; i < N; i++) begin
            reset[i] = 1'b0; req_valid[i] = 1'b0; req_rw[i] = 1'b0; req_addr[i] = '0;
            flush_req[i] = 1'b0; stats_clr[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rst_resp_valid", resp_valid[0], 0);
        check("rst_flush_done", flush_done[0], 0);
        check("rst_accesses", acc[0], 0);
        check("rst_writebacks", wbc[0], 0);
        for (int i = 0; i < N; i++) reset[i] = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready[0], 1);

        // Reset/hit and LRU on the write-back instance (set 0)
        xact(0, 0, 16'h0000, 0, 0, 0, "rd0000_first");
        xact(0, 0, 16'h0008, 1, 0, 0, "rd0008_same_line");
        check("hits_after_2", hit[0], 1);
        check("misses_after_2", mis[0], 1);
        xact(0, 0, 16'h0000, 1, 0, 0, "lru_rd0000");
        xact(0, 0, 16'h0040, 0, 0, 0, "lru_rd0040_fill");
        xact(0, 0, 16'h0000, 1, 0, 0, "lru_rd0000_touch");
        xact(0, 0, 16'h0080, 0, 1, 0, "lru_rd0080_evict");
        xact(0, 0, 16'h0000, 1, 0, 0, "lru_rd0000_kept");
        xact(0, 0, 16'h0040, 0, 1, 0, "lru_rd0040_gone");
        check("lru_accesses", acc[0], 8);
        check("lru_evictions", evc[0], 2);

        // Writeback of a dirty victim (set 1)
        clear_stats(0);
        check("clr_accesses", acc[0], 0);
        xact(0, 1, 16'h0010, 0, 0, 0, "wb_wr0010");
        xact(0, 0, 16'h0050, 0, 0, 0, "wb_rd0050");
        xact(0, 0, 16'h0090, 0, 1, 1, "wb_rd0090");
        check("wb_evictions", evc[0], 1);
        check("wb_writebacks", wbc[0], 1);
        check("wb_reads", rd[0], 2);
        check("wb_writes", wr[0], 1);

        // Flush: two dirty lines, one per set
        clear_stats(0);
        xact(0, 1, 16'h0000, 1, 0, 0, "fl_wr0000");
        xact(0, 1, 16'h0010, 0, 1, 0, "fl_wr0010");
        check("fl_wb_before", wbc[0], 0);
        flush_req[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush_req[0] = 1'b0;
        check("fl_ready_low", req_ready[0], 0);
        n = 1;
        while (!flush_done[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("fl_done_cycle", n, 4);
        @(negedge clk);
        check("fl_ready_back", req_ready[0], 1);
        check("fl_writebacks", wbc[0], 2);
        xact(0, 0, 16'h0000, 0, 0, 0, "fl_rd0000_miss");

        // Write-through / no-write-allocate instance
        xact(1, 1, 16'h0100, 0, 0, 0, "wt_wr0100_miss");
        xact(1, 0, 16'h0100, 0, 0, 0, "wt_rd0100_miss");
        xact(1, 1, 16'h0100, 1, 0, 0, "wt_wr0100_hit");
        check("wt_evictions", evc[1], 0);
        check("wt_writebacks", wbc[1], 0);
        check("wt_misses", mis[1], 2);
        check("wt_hits", hit[1], 1);
        check("wt_writes", wr[1], 2);
        xact(1, 0, 16'h0140, 0, 0, 0, "wt_rd0140_fill");
        xact(1, 0, 16'h0180, 0, 1, 0, "wt_rd0180_clean_evict");
        xact(1, 1, 16'h01C0, 0, 0, 0, "wt_wr01c0_full_noalloc");
        check("wt_evictions_end", evc[1], 1);

        // Saturating 2-bit counters
        for (int i = 0; i < 5; i++) xact(2, 0, 16'h0000, (i != 0), 0, 0, "sat_rd");
        check("sat_accesses", acc2, 3);
        check("sat_reads", rd2, 3);
        check("sat_hits", hit2, 3);
        check("sat_misses", mis2, 1);
        check("sat_writes", wr2, 0);
        check("sat_evictions", evc2, 0);
        check("sat_writebacks", wbc2, 0);

        // Reset during LOOKUP aborts the request
        req_valid[2] = 1'b1;
        req_rw[2]    = 1'b0;
        req_addr[2]  = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        reset[2]     = 1'b0;
        @(negedge clk);
        check("abort_acc_in_reset", acc2, 0);
        reset[2] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid[2]) seen = 1'b1;
        end
        check("abort_no_resp", seen, 0);
        xact(2, 0, 16'h0000, 0, 0, 0, "abort_rd0000_miss");
        check("abort_accesses", acc2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
